// File: rtl/ahblite_gpio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pkg
// Purpose  : Shared definitions for the AHB-Lite GPIO controller: register
//            offsets (word index = HADDR[4:2]), HTRANS encoding and the
//            default bank width.
// Revision : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  localparam int c_default_width = 8;

  // Word index of each register, i.e. HADDR[4:2].
  typedef enum logic [2:0] {
    c_reg_dout     = 3'd0,
    c_reg_dir      = 3'd1,
    c_reg_din      = 3'd2,
    c_reg_irq_en   = 3'd3,
    c_reg_edge     = 3'd4,
    c_reg_irq_stat = 3'd5
  } reg_addr_e;

  typedef enum logic [1:0] {
    c_htrans_idle   = 2'b00,
    c_htrans_busy   = 2'b01,
    c_htrans_nonseq = 2'b10,
    c_htrans_seq    = 2'b11
  } htrans_e;

  // Only NONSEQ and SEQ carry a real transfer; both have bit 1 set.
  function automatic logic htrans_active(input htrans_e htrans);
    return htrans[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahblite_gpio_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ahblite_gpio_ctrl_if
// Purpose  : AHB-Lite slave-port bundle (address/control, write data and
//            response) for the GPIO controller.
// Ports    : master modport drives HSEL/HADDR/HTRANS/HSIZE/HPROT/HWRITE/
//            HWDATA/HREADY and samples HREADYOUT/HRDATA/HRESP; slave modport
//            is the mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface ahblite_gpio_ctrl_if;
  import gpio_pkg::*;

  logic        HSEL;
  logic [31:0] HADDR;
  htrans_e     HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );

endinterface
`default_nettype wire

// File: rtl/ahblite_gpio_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : gpio_sync_edge
// Purpose  : Multi-flop input synchroniser for a GPIO bank plus one-cycle
//            edge history, producing synchronised level and rise/fall pulses.
// Ports    : clk, rst_n (async active-low), i_pad (raw pad values),
//            o_sync (synchronised level), o_rise / o_fall (one-cycle pulses).
// Revision : 1.0 - initial release
// ============================================================================
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] i_pad,
  output logic      [WIDTH-1:0] o_sync,
  output logic      [WIDTH-1:0] o_rise,
  output logic      [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_pad;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_prev <= o_sync;
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/ahblite_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ahblite_gpio_ctrl
// Purpose  : Zero-wait-state AHB-Lite GPIO slave: direction/output registers,
//            synchronised input readback, edge-detect interrupts with per-pin
//            enable, sticky status and write-1-to-clear.
// Ports    : HCLK, HRESETn (async active-low), bus (AHB-Lite slave modport),
//            GPIO (bidirectional pins), IRQ (level interrupt).
// Revision : 1.0 - initial release
// ============================================================================
module ahblite_gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = c_default_width,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             HCLK,
  input  wire logic             HRESETn,
  ahblite_gpio_ctrl_if.slave    bus,
  inout  wire logic [WIDTH-1:0] GPIO,
  output logic                  IRQ
);

  // Data-phase copy of the accepted address phase.
  logic             r_dp_valid;
  logic             r_dp_write;
  logic [2:0]       r_dp_addr;

  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_irq_en;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_irq_stat;

  logic             w_addr_phase;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_rsel;
  logic             w_unused;

  assign w_addr_phase = bus.HSEL & bus.HREADY & htrans_active(bus.HTRANS);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
    end else begin
      // Cleared on idle/unselected cycles so no stale access fires.
      r_dp_valid <= w_addr_phase;
      if (w_addr_phase) begin
        r_dp_write <= bus.HWRITE;
        r_dp_addr  <= bus.HADDR[4:2];
      end
    end
  end

  assign w_wr    = r_dp_valid & r_dp_write;
  assign w_wdata = bus.HWDATA[WIDTH-1:0];
  assign w_w1c   = (w_wr && (r_dp_addr == c_reg_irq_stat)) ? w_wdata : '0;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (HCLK),
    .rst_n  (HRESETn),
    .i_pad  (GPIO),
    .o_sync (w_sync),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_event = (r_edge & w_fall) | (~r_edge & w_rise);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dout     <= '0;
      r_dir      <= '0;
      r_irq_en   <= '0;
      r_edge     <= '0;
      r_irq_stat <= '0;
    end else begin
      if (w_wr) begin
        case (r_dp_addr)
          c_reg_dout:   r_dout   <= w_wdata;
          c_reg_dir:    r_dir    <= w_wdata;
          c_reg_irq_en: r_irq_en <= w_wdata;
          c_reg_edge:   r_edge   <= w_wdata;
          default:      ;
        endcase
      end
      // OR-ing the event after the clear lets a same-cycle event win.
      r_irq_stat <= (r_irq_stat & ~w_w1c) | w_event;
    end
  end

  always_comb begin
    w_rsel = '0;
    if (r_dp_valid && !r_dp_write) begin
      case (r_dp_addr)
        c_reg_dout:     w_rsel = r_dout;
        c_reg_dir:      w_rsel = r_dir;
        c_reg_din:      w_rsel = w_sync;
        c_reg_irq_en:   w_rsel = r_irq_en;
        c_reg_edge:     w_rsel = r_edge;
        c_reg_irq_stat: w_rsel = r_irq_stat;
        default:        w_rsel = '0;
      endcase
    end
  end

  assign bus.HRDATA    = 32'(w_rsel);
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  assign IRQ = |(r_irq_stat & r_irq_en);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign GPIO[i] = r_dir[i] ? r_dout[i] : 1'bz;
  end

  // Bus fields this slave deliberately ignores.
  assign w_unused = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HSIZE, bus.HPROT,
                      bus.HWDATA};

endmodule
`default_nettype wire

// File: tb/tb_ahblite_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahblite_gpio_ctrl
// Purpose  : Directed self-checking bench for ahblite_gpio_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahblite_gpio_ctrl;
  import gpio_pkg::*;

  localparam int c_width = 8;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic IRQ;
  wire  [c_width-1:0] gpio;
  logic [c_width-1:0] r_tb_oe;
  logic [c_width-1:0] r_tb_out;
  logic [31:0] r_rd;
  logic r_resp_bad;
  int   n_pass;
  int   n_fail;
  int   n_total;

  always #5 HCLK = ~HCLK;

  ahblite_gpio_ctrl_if bus();

  for (genvar i = 0; i < c_width; i++) begin : g_tb_drv
    assign gpio[i] = r_tb_oe[i] ? r_tb_out[i] : 1'bz;
  end
  pulldown (gpio);

  ahblite_gpio_ctrl #(
    .WIDTH       (c_width),
    .SYNC_STAGES (2)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus),
    .GPIO    (gpio),
    .IRQ     (IRQ)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge HCLK);
      #1;
      if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) r_resp_bad = 1'b1;
    end
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = c_htrans_idle;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h0;
  endtask

  task automatic addr_phase(input logic [31:0] addr, input logic wr);
    bus.HSEL   = 1'b1;
    bus.HTRANS = c_htrans_nonseq;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    addr_phase(addr, 1'b1);
    tick();
    bus_idle();
    bus.HWDATA = data;
    tick();
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    addr_phase(addr, 1'b0);
    tick();
    bus_idle();
    data = bus.HRDATA;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(addr, d);
    check(tag, d, exp);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    r_resp_bad = 1'b0;
    r_tb_oe = '0; r_tb_out = '0;
    bus_idle();
    bus.HREADY = 1'b1;
    bus.HWDATA = 32'h0;
    bus.HSIZE  = 3'b010;
    bus.HPROT  = 4'b0011;
    HRESETn    = 1'b0;

    // 1: reset state and all offsets read zero
    tick(3);
    check("rst_hrdata", bus.HRDATA, 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'h0);
    check("rst_gpio", {24'b0, gpio}, 32'h0);
    HRESETn = 1'b1;
    tick(2);
    for (int a = 0; a < 7; a++) begin
      read_check($sformatf("rst_reg_%02h", a * 4), 32'(a * 4), 32'h0);
    end
    check("rst_irq_after", {31'b0, IRQ}, 32'h0);

    // 2: direction/output and input readback
    ahb_write(32'h04, 32'h0000_000F);
    ahb_write(32'h00, 32'h0000_00A5);
    check("gpio_drive", {24'b0, gpio}, 32'h05);
    r_tb_oe  = 8'hF0;
    r_tb_out = 8'h30;
    tick(2);
    read_check("din_mixed", 32'h08, 32'h35);
    read_check("dout_rb", 32'h00, 32'hA5);
    read_check("dir_rb", 32'h04, 32'h0F);
    read_check("stat_rise_all", 32'h14, 32'h35);
    ahb_write(32'h14, 32'hFFFF_FFFF);
    read_check("stat_clr_all", 32'h14, 32'h0);

    // hand all pins to the bench
    ahb_write(32'h04, 32'h0);
    r_tb_oe  = 8'hFF;
    r_tb_out = 8'h30;
    tick(4);
    read_check("stat_no_fall", 32'h14, 32'h0);

    // 3: rising-edge interrupt latency and W1C
    ahb_write(32'h0C, 32'h01);
    ahb_write(32'h10, 32'h00);
    r_tb_out = 8'h31;
    tick(2);
    check("irq_before_3", {31'b0, IRQ}, 32'h0);
    tick(1);
    check("irq_at_3", {31'b0, IRQ}, 32'h1);
    read_check("stat_rise0", 32'h14, 32'h01);
    ahb_write(32'h14, 32'h01);
    read_check("stat_w1c0", 32'h14, 32'h0);
    check("irq_cleared", {31'b0, IRQ}, 32'h0);

    // 4: falling-edge select, masked interrupt
    ahb_write(32'h10, 32'h02);
    tick(3);
    read_check("edge_wr_no_evt", 32'h14, 32'h0);
    r_tb_out = 8'h33;
    tick(4);
    read_check("stat_rise1_ign", 32'h14, 32'h0);
    r_tb_out = 8'h31;
    tick(4);
    read_check("stat_fall1", 32'h14, 32'h02);
    check("irq_masked", {31'b0, IRQ}, 32'h0);
    ahb_write(32'h14, 32'h02);
    read_check("stat_w1c1", 32'h14, 32'h0);

    // 5: event coinciding with W1C of the same bit
    r_tb_out = 8'h33;
    tick(4);
    r_tb_out = 8'h31;
    tick(1);
    addr_phase(32'h14, 1'b1);
    tick(1);
    bus_idle();
    bus.HWDATA = 32'h02;
    tick(1);
    read_check("evt_beats_w1c", 32'h14, 32'h02);
    ahb_write(32'h14, 32'h02);
    read_check("stat_w1c1_b", 32'h14, 32'h0);

    // 6: pipelined write->read, ignored writes, unmapped space
    addr_phase(32'h00, 1'b1);
    tick(1);
    bus.HWDATA = 32'h3C;
    addr_phase(32'h00, 1'b0);
    tick(1);
    bus_idle();
    check("b2b_wr_rd", bus.HRDATA, 32'h3C);
    bus.HSEL = 1'b1; bus.HTRANS = c_htrans_idle; bus.HWRITE = 1'b1; bus.HADDR = 32'h00;
    tick(1);
    bus_idle(); bus.HWDATA = 32'hFF;
    tick(1);
    read_check("idle_wr_ign", 32'h00, 32'h3C);
    bus.HSEL = 1'b0; bus.HTRANS = c_htrans_nonseq; bus.HWRITE = 1'b1; bus.HADDR = 32'h00;
    tick(1);
    bus_idle(); bus.HWDATA = 32'hFF;
    tick(1);
    read_check("unsel_wr_ign", 32'h00, 32'h3C);
    ahb_write(32'h1C, 32'hFF);
    read_check("unmapped_rd", 32'h1C, 32'h0);
    read_check("unmapped_alias", 32'h00, 32'h3C);

    // asynchronous reset in the middle of a data phase
    ahb_write(32'h10, 32'hFF);
    ahb_write(32'h0C, 32'hFF);
    r_tb_oe = 8'h00;
    tick(5);
    read_check("stat_pre_rst", 32'h14, 32'h31);
    check("irq_pre_rst", {31'b0, IRQ}, 32'h1);
    addr_phase(32'h00, 1'b0);
    tick(1);
    bus_idle();
    check("rd_pre_rst", bus.HRDATA, 32'h3C);
    #2;
    HRESETn = 1'b0;
    #1;
    check("rst_async_rd", bus.HRDATA, 32'h0);
    check("rst_async_irq", {31'b0, IRQ}, 32'h0);
    tick(2);
    HRESETn = 1'b1;
    tick(1);
    read_check("post_rst_dout", 32'h00, 32'h0);
    read_check("post_rst_dir", 32'h04, 32'h0);
    read_check("post_rst_ien", 32'h0C, 32'h0);
    read_check("post_rst_edge", 32'h10, 32'h0);
    read_check("post_rst_stat", 32'h14, 32'h0);
    check("post_rst_irq", {31'b0, IRQ}, 32'h0);

    tick(1);
    check("resp_const", {31'b0, r_resp_bad}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
